// File: rtl/advance_4bit_adder_if.sv
// rtl/advance_4bit_adder_if.sv - operand and result bundle for the registered 4-bit CLA adder
interface advance_4bit_adder_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       cout;

    modport master (
        output A,
        output B,
        input  S,
        input  cout
    );

    modport slave (
        input  A,
        input  B,
        output S,
        output cout
    );
endinterface

// File: rtl/advance_4bit_adder.sv
// rtl/advance_4bit_adder.sv - 4-bit carry-lookahead adder with registered {cout, S}
module advance_4bit_adder (
    input  logic                     clk,
    input  logic                     rst_n,
    advance_4bit_adder_if.slave      bus
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s_next;

    assign g = bus.A & bus.B;
    assign p = bus.A ^ bus.B;

    // Every carry is a flat sum of products of g/p so no carry waits on its neighbour.
    assign c[0] = 1'b0;
    assign c[1] = g[0];
    assign c[2] = g[1] | (p[1] & g[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign s_next = p ^ c[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.S    <= 4'b0000;
            bus.cout <= 1'b0;
        end else begin
            bus.S    <= s_next;
            bus.cout <= c[4];
        end
    end
endmodule

// File: tb/tb_advance_4bit_adder.sv
// tb/tb_advance_4bit_adder.sv - scoreboard bench for advance_4bit_adder
module tb_advance_4bit_adder;
    logic clk;
    logic rst_n;

    advance_4bit_adder_if bus ();

    advance_4bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0] exp;
        logic [3:0] a;
        logic [3:0] b;
    } item_t;

    item_t q[$];
    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: results appear one edge after the operands; a reset edge discards pending work.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else if (q.size() > 0) begin
            item_t it;
            #1;
            it = q.pop_front();
            tests++;
            if ({bus.cout, bus.S} !== it.exp) begin
                fails++;
                $display("FAIL sum a=%h b=%h got %h expected %h", it.a, it.b, {bus.cout, bus.S}, it.exp);
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
        item_t it;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        it.exp = exp;
        it.a = a;
        it.b = b;
        q.push_back(it);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (bus.S !== 4'h0 || bus.cout !== 1'b0) begin
            fails++;
            $display("FAIL %s got %h expected 00", name, {bus.cout, bus.S});
        end
    endtask

    initial begin
        logic [3:0] av;
        logic [3:0] bv;
        rst_n = 1'b0;
        bus.A = 4'hF;
        bus.B = 4'hF;

        // Reset held with all-ones operands while the clock runs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            item_t it;
            it.exp = 5'h1E;
            it.a = 4'hF;
            it.b = 4'hF;
            q.push_back(it);
        end

        // A = 0: identity sweep
        for (int i = 0; i < 16; i++) begin
            bv = 4'(i);
            drive(4'h0, bv, 5'(i));
        end

        // A = 1: carry sweep, B = 15 rolls into cout
        for (int i = 0; i < 16; i++) begin
            bv = 4'(i);
            drive(4'h1, bv, (i == 15) ? 5'h10 : 5'(i + 1));
        end

        // Full-propagate chain with and without a generate at bit 0
        drive(4'b0101, 4'b1010, 5'h0F);
        drive(4'b0101, 4'b1011, 5'h10);
        drive(4'h8, 4'h8, 5'h10);
        drive(4'h7, 4'h9, 5'h10);

        // Exhaustive sweep, expected values from integer arithmetic
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                av = 4'(i);
                bv = 4'(j);
                drive(av, bv, 5'(i + j));
            end
        end

        // Mid-stream asynchronous reset between edges
        drive(4'h3, 4'h4, 5'h07);
        @(negedge clk);
        tests++;
        if ({bus.cout, bus.S} !== 5'h07) begin
            fails++;
            $display("FAIL pre_async got %h expected 07", {bus.cout, bus.S});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_clear");
        @(posedge clk);
        #1;
        check_zero("async_hold");
        @(negedge clk);
        rst_n = 1'b1;
        bus.A = 4'h9;
        bus.B = 4'h9;
        begin
            item_t it;
            it.exp = 5'h12;
            it.a = 4'h9;
            it.b = 4'h9;
            q.push_back(it);
        end
        drive(4'hA, 4'h6, 5'h10);
        drive(4'h2, 4'h3, 5'h05);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
